// File: rtl/trace_capture_if.sv
// Host-side bundle for trace_capture: capture control, channel taps and playback port.
// master drives the iw_* inputs, slave (the trace buffer) drives the ow_* outputs.
interface trace_if #(
  parameter int CHANNELS = 4,
  parameter int DATA_W   = 24,
  parameter int DEPTH    = 64,
  parameter int TS_W     = 16
);
  localparam int AW = $clog2(DEPTH);

  logic                       iw_arm;
  logic                       iw_trig;
  logic [AW-1:0]              iw_post_cnt;
  logic                       iw_sample_en;
  logic [CHANNELS*DATA_W-1:0] iw_ch_data;
  logic                       iw_rd_req;
  logic                       ow_rd_valid;
  logic [CHANNELS*DATA_W-1:0] ow_rd_data;
  logic [TS_W-1:0]            ow_rd_ts;
  logic                       ow_rd_last;
  logic [1:0]                 ow_state;
  logic                       ow_wrapped;
  logic [AW-1:0]              ow_trig_idx;

  modport master (
    output iw_arm, iw_trig, iw_post_cnt, iw_sample_en, iw_ch_data, iw_rd_req,
    input  ow_rd_valid, ow_rd_data, ow_rd_ts, ow_rd_last, ow_state, ow_wrapped, ow_trig_idx
  );

  modport slave (
    input  iw_arm, iw_trig, iw_post_cnt, iw_sample_en, iw_ch_data, iw_rd_req,
    output ow_rd_valid, ow_rd_data, ow_rd_ts, ow_rd_last, ow_state, ow_wrapped, ow_trig_idx
  );
endinterface

// File: rtl/trace_capture.sv
// Circular trace buffer: capture while armed, freeze post_cnt samples after trigger, play back oldest-first.
// Optional macro TRACE_TIMESTAMP_EN stores a free-running cycle stamp with every entry.
module trace_capture #(
  parameter int CHANNELS = 4,
  parameter int DATA_W   = 24,
  parameter int DEPTH    = 64,
  parameter int TS_W     = 16
) (
  input logic  iw_clk,
  input logic  iw_rst_n,
  trace_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int W  = CHANNELS * DATA_W;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ARMED = 2'd1;
  localparam logic [1:0] S_POST  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  // Keep the trigger sample inside the window even for the largest request.
  function automatic logic [AW-1:0] clamp_post(input logic [AW-1:0] p);
    logic [AW:0] wide;
    wide = {1'b0, p};
    if (wide > (AW+1)'(DEPTH-1)) return AW'(DEPTH-1);
    else                         return p;
  endfunction

  logic [W-1:0] mem [DEPTH];

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic          wrapped_q, wrapped_d;
  logic [AW-1:0] post_q, post_d;
  logic [AW-1:0] remaining_q, remaining_d;
  logic [AW-1:0] trig_ptr_q, trig_ptr_d;
  logic [AW-1:0] trig_idx_q, trig_idx_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   rd_left_q, rd_left_d;
  logic          rd_valid_q, rd_valid_d;
  logic          rd_last_q, rd_last_d;
  logic [W-1:0]  rd_data_q, rd_data_d;
  logic          we_s, rd_issue_s, enter_done_s;
  logic [AW-1:0] start_s;

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    wrapped_d    = wrapped_q;
    post_d       = post_q;
    remaining_d  = remaining_q;
    trig_ptr_d   = trig_ptr_q;
    trig_idx_d   = trig_idx_q;
    rd_ptr_d     = rd_ptr_q;
    rd_left_d    = rd_left_q;
    rd_valid_d   = 1'b0;
    rd_last_d    = 1'b0;
    we_s         = 1'b0;
    rd_issue_s   = 1'b0;
    enter_done_s = 1'b0;
    start_s      = '0;

    case (state_q)
      S_IDLE: begin
        state_d = S_IDLE;
      end
      S_ARMED: begin
        if (bus.iw_trig) begin
          we_s       = 1'b1;
          trig_ptr_d = wr_ptr_q;
          if (post_q == AW'(0)) begin
            state_d      = S_DONE;
            enter_done_s = 1'b1;
          end else begin
            state_d     = S_POST;
            remaining_d = post_q;
          end
        end else begin
          we_s = bus.iw_sample_en;
        end
      end
      S_POST: begin
        if (bus.iw_sample_en) begin
          we_s        = 1'b1;
          remaining_d = remaining_q - AW'(1);
          if (remaining_q == AW'(1)) begin
            state_d      = S_DONE;
            enter_done_s = 1'b1;
          end else begin
            state_d = S_POST;
          end
        end else begin
          we_s = 1'b0;
        end
      end
      S_DONE: begin
        if (rd_valid_q && rd_last_q) begin
          state_d = S_IDLE;
        end else if (bus.iw_rd_req && (rd_left_q != (AW+1)'(0))) begin
          rd_issue_s = 1'b1;
          rd_valid_d = 1'b1;
          rd_last_d  = (rd_left_q == (AW+1)'(1));
          rd_ptr_d   = rd_ptr_q + AW'(1);
          rd_left_d  = rd_left_q - (AW+1)'(1);
        end else begin
          rd_issue_s = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (we_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
      if (wr_ptr_q == AW'(DEPTH-1)) wrapped_d = 1'b1;
      else                          wrapped_d = wrapped_q;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    // Playback window is fixed from the pointer state left by the final write.
    if (enter_done_s) begin
      start_s    = wrapped_d ? wr_ptr_d : AW'(0);
      rd_ptr_d   = start_s;
      rd_left_d  = wrapped_d ? (AW+1)'(DEPTH) : {1'b0, wr_ptr_d};
      trig_idx_d = trig_ptr_d - start_s;
    end else begin
      start_s = '0;
    end

    if (bus.iw_arm) begin
      state_d    = S_ARMED;
      wr_ptr_d   = '0;
      wrapped_d  = 1'b0;
      post_d     = clamp_post(bus.iw_post_cnt);
      trig_idx_d = '0;
      rd_left_d  = '0;
      rd_valid_d = 1'b0;
      rd_last_d  = 1'b0;
      we_s       = 1'b0;
      rd_issue_s = 1'b0;
    end else begin
      post_d = post_q;
    end

    if (rd_issue_s) rd_data_d = mem[rd_ptr_q];
    else            rd_data_d = rd_data_q;
  end

  // Capture RAM, contents undefined until written.
  always_ff @(posedge iw_clk) begin
    if (we_s) mem[wr_ptr_q] <= bus.iw_ch_data;
  end

  // Control and output registers.
  always_ff @(posedge iw_clk or negedge iw_rst_n) begin
    if (!iw_rst_n) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      wrapped_q   <= 1'b0;
      post_q      <= '0;
      remaining_q <= '0;
      trig_ptr_q  <= '0;
      trig_idx_q  <= '0;
      rd_ptr_q    <= '0;
      rd_left_q   <= '0;
      rd_valid_q  <= 1'b0;
      rd_last_q   <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      wrapped_q   <= wrapped_d;
      post_q      <= post_d;
      remaining_q <= remaining_d;
      trig_ptr_q  <= trig_ptr_d;
      trig_idx_q  <= trig_idx_d;
      rd_ptr_q    <= rd_ptr_d;
      rd_left_q   <= rd_left_d;
      rd_valid_q  <= rd_valid_d;
      rd_last_q   <= rd_last_d;
      rd_data_q   <= rd_data_d;
    end
  end

`ifdef TRACE_TIMESTAMP_EN
  logic [TS_W-1:0] ts_mem [DEPTH];
  logic [TS_W-1:0] ts_q, ts_d, rd_ts_q, rd_ts_d;

  always_comb begin
    ts_d = ts_q + TS_W'(1);
    if (rd_issue_s) rd_ts_d = ts_mem[rd_ptr_q];
    else            rd_ts_d = rd_ts_q;
  end

  // Stamp RAM written alongside the data RAM.
  always_ff @(posedge iw_clk) begin
    if (we_s) ts_mem[wr_ptr_q] <= ts_q;
  end

  // Free-running cycle counter and stamp output register.
  always_ff @(posedge iw_clk or negedge iw_rst_n) begin
    if (!iw_rst_n) begin
      ts_q    <= '0;
      rd_ts_q <= '0;
    end else begin
      ts_q    <= ts_d;
      rd_ts_q <= rd_ts_d;
    end
  end

  assign bus.ow_rd_ts = rd_ts_q;
`else
  assign bus.ow_rd_ts = '0;
`endif

  assign bus.ow_rd_valid = rd_valid_q;
  assign bus.ow_rd_data  = rd_data_q;
  assign bus.ow_rd_last  = rd_last_q;
  assign bus.ow_state    = state_q;
  assign bus.ow_wrapped  = wrapped_q;
  assign bus.ow_trig_idx = trig_idx_q;
endmodule

// File: tb/tb_trace_capture.sv
// Directed bench for trace_capture with CHANNELS=2, DATA_W=24, DEPTH=8.
module tb_trace_capture;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  trace_if #(.CHANNELS(2), .DATA_W(24), .DEPTH(8), .TS_W(16)) bus ();

  trace_capture #(.CHANNELS(2), .DATA_W(24), .DEPTH(8), .TS_W(16)) dut (
    .iw_clk(clk), .iw_rst_n(rst_n), .bus(bus)
  );

  function automatic logic [47:0] mk(input int n);
    logic [23:0] v;
    v = 24'(n);
    return {v ^ 24'h5A5A5A, v};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    bus.iw_arm = 1'b0; bus.iw_trig = 1'b0; bus.iw_sample_en = 1'b0;
    bus.iw_rd_req = 1'b0; bus.iw_ch_data = '0;
  endtask

  task automatic arm(input logic [2:0] post);
    quiet();
    bus.iw_arm = 1'b1; bus.iw_post_cnt = post;
    tick();
    bus.iw_arm = 1'b0;
  endtask

  task automatic sample(input int n, input logic en, input logic trig);
    bus.iw_ch_data = mk(n); bus.iw_sample_en = en; bus.iw_trig = trig;
    tick();
    quiet();
  endtask

  task automatic test_reset();
    quiet(); bus.iw_post_cnt = 3'd0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (bus.ow_state !== 2'd0) $display("FAIL reset_state got %0d want 0", bus.ow_state); else n_pass++;
    n_checks++; if (bus.ow_rd_valid !== 1'b0 || bus.ow_wrapped !== 1'b0 || bus.ow_trig_idx !== 3'd0 || bus.ow_rd_data !== 48'd0)
      $display("FAIL reset_outputs got v=%b w=%b ti=%0d d=%h want zeros", bus.ow_rd_valid, bus.ow_wrapped, bus.ow_trig_idx, bus.ow_rd_data); else n_pass++;
    rst_n = 1'b1;
    bus.iw_trig = 1'b1; bus.iw_rd_req = 1'b1; bus.iw_sample_en = 1'b1;
    tick();
    quiet();
    n_checks++; if (bus.ow_state !== 2'd0 || bus.ow_rd_valid !== 1'b0)
      $display("FAIL idle_ignore got state=%0d valid=%b want 0 0", bus.ow_state, bus.ow_rd_valid); else n_pass++;
  endtask

  task automatic test_basic();
    logic [15:0] prev_ts;
    prev_ts = '0;
    arm(3'd2);
    n_checks++; if (bus.ow_state !== 2'd1) $display("FAIL basic_armed got %0d want 1", bus.ow_state); else n_pass++;
    for (int n = 0; n < 5; n++) begin
      sample(n, 1'b1, n == 2);
      if (n == 2) begin
        n_checks++; if (bus.ow_state !== 2'd2) $display("FAIL basic_post got %0d want 2", bus.ow_state); else n_pass++;
      end
    end
    n_checks++; if (bus.ow_state !== 2'd3) $display("FAIL basic_done got %0d want 3", bus.ow_state); else n_pass++;
    n_checks++; if (bus.ow_wrapped !== 1'b0) $display("FAIL basic_wrapped got %b want 0", bus.ow_wrapped); else n_pass++;
    n_checks++; if (bus.ow_trig_idx !== 3'd2) $display("FAIL basic_trig_idx got %0d want 2", bus.ow_trig_idx); else n_pass++;
    for (int k = 0; k < 5; k++) begin
      bus.iw_rd_req = 1'b1;
      tick();
      n_checks++; if (bus.ow_rd_valid !== 1'b1 || bus.ow_rd_data !== mk(k) || bus.ow_rd_last !== (k == 4))
        $display("FAIL basic_play%0d got v=%b d=%h l=%b want 1 %h %b", k, bus.ow_rd_valid, bus.ow_rd_data, bus.ow_rd_last, mk(k), k == 4); else n_pass++;
`ifdef TRACE_TIMESTAMP_EN
      if (k > 0) begin
        n_checks++; if (bus.ow_rd_ts !== prev_ts + 16'd1) $display("FAIL basic_ts%0d got %0d want %0d", k, bus.ow_rd_ts, prev_ts + 16'd1); else n_pass++;
      end
`else
      n_checks++; if (bus.ow_rd_ts !== 16'd0) $display("FAIL basic_ts%0d got %0d want 0", k, bus.ow_rd_ts); else n_pass++;
`endif
      prev_ts = bus.ow_rd_ts;
    end
    tick();
    bus.iw_rd_req = 1'b0;
    n_checks++; if (bus.ow_rd_valid !== 1'b0 || bus.ow_state !== 2'd0)
      $display("FAIL basic_end got valid=%b state=%0d want 0 0", bus.ow_rd_valid, bus.ow_state); else n_pass++;
  endtask

  task automatic test_wrap();
    arm(3'd3);
    for (int n = 0; n < 20; n++) sample(n, 1'b1, n == 16);
    n_checks++; if (bus.ow_state !== 2'd3 || bus.ow_wrapped !== 1'b1 || bus.ow_trig_idx !== 3'd4)
      $display("FAIL wrap_status got s=%0d w=%b ti=%0d want 3 1 4", bus.ow_state, bus.ow_wrapped, bus.ow_trig_idx); else n_pass++;
    for (int k = 0; k < 8; k++) begin
      bus.iw_rd_req = 1'b1;
      tick();
      n_checks++; if (bus.ow_rd_valid !== 1'b1 || bus.ow_rd_data !== mk(12 + k) || bus.ow_rd_last !== (k == 7))
        $display("FAIL wrap_play%0d got v=%b d=%h l=%b want 1 %h %b", k, bus.ow_rd_valid, bus.ow_rd_data, bus.ow_rd_last, mk(12 + k), k == 7); else n_pass++;
    end
    bus.iw_rd_req = 1'b0;
    tick();
    n_checks++; if (bus.ow_state !== 2'd0) $display("FAIL wrap_idle got %0d want 0", bus.ow_state); else n_pass++;
  endtask

  task automatic test_max_post();
    arm(3'd7);
    for (int n = 0; n < 8; n++) sample(n, 1'b1, n == 0);
    n_checks++; if (bus.ow_state !== 2'd3 || bus.ow_trig_idx !== 3'd0 || bus.ow_wrapped !== 1'b1)
      $display("FAIL maxpost_status got s=%0d ti=%0d w=%b want 3 0 1", bus.ow_state, bus.ow_trig_idx, bus.ow_wrapped); else n_pass++;
    for (int k = 0; k < 8; k++) begin
      bus.iw_rd_req = 1'b1;
      tick();
      n_checks++; if (bus.ow_rd_valid !== 1'b1 || bus.ow_rd_data !== mk(k))
        $display("FAIL maxpost_play%0d got v=%b d=%h want 1 %h", k, bus.ow_rd_valid, bus.ow_rd_data, mk(k)); else n_pass++;
    end
    bus.iw_rd_req = 1'b0;
    tick();
  endtask

  task automatic test_gaps();
    int exp_vals[4];
    exp_vals[0] = 32'h11; exp_vals[1] = 32'h33; exp_vals[2] = 32'hABCDEF; exp_vals[3] = 32'h55;
    arm(3'd1);
    sample(32'h11, 1'b1, 1'b0);
    sample(32'h22, 1'b0, 1'b0);
    sample(32'h33, 1'b1, 1'b0);
    sample(32'hABCDEF, 1'b0, 1'b1);
    sample(32'h44, 1'b0, 1'b0);
    n_checks++; if (bus.ow_state !== 2'd2) $display("FAIL gaps_post got %0d want 2", bus.ow_state); else n_pass++;
    sample(32'h55, 1'b1, 1'b0);
    n_checks++; if (bus.ow_state !== 2'd3 || bus.ow_trig_idx !== 3'd2)
      $display("FAIL gaps_status got s=%0d ti=%0d want 3 2", bus.ow_state, bus.ow_trig_idx); else n_pass++;
    for (int k = 0; k < 4; k++) begin
      bus.iw_rd_req = 1'b1;
      tick();
      n_checks++; if (bus.ow_rd_valid !== 1'b1 || bus.ow_rd_data !== mk(exp_vals[k]) || bus.ow_rd_last !== (k == 3))
        $display("FAIL gaps_play%0d got v=%b d=%h l=%b want 1 %h %b", k, bus.ow_rd_valid, bus.ow_rd_data, bus.ow_rd_last, mk(exp_vals[k]), k == 3); else n_pass++;
    end
    bus.iw_rd_req = 1'b0;
    tick();
  endtask

  task automatic test_arm_priority();
    arm(3'd2);
    for (int n = 0; n < 5; n++) sample(n, 1'b1, n == 2);
    for (int k = 0; k < 2; k++) begin
      bus.iw_rd_req = 1'b1;
      tick();
      n_checks++; if (bus.ow_rd_data !== mk(k)) $display("FAIL rearm_read%0d got %h want %h", k, bus.ow_rd_data, mk(k)); else n_pass++;
    end
    bus.iw_arm = 1'b1; bus.iw_post_cnt = 3'd1;
    tick();
    quiet();
    n_checks++; if (bus.ow_rd_valid !== 1'b0 || bus.ow_state !== 2'd1)
      $display("FAIL rearm_drop got valid=%b state=%0d want 0 1", bus.ow_rd_valid, bus.ow_state); else n_pass++;
    bus.iw_arm = 1'b1; bus.iw_trig = 1'b1; bus.iw_sample_en = 1'b1;
    tick();
    quiet();
    n_checks++; if (bus.ow_state !== 2'd1) $display("FAIL arm_trig_same got %0d want 1", bus.ow_state); else n_pass++;
    sample(7, 1'b1, 1'b1);
    n_checks++; if (bus.ow_state !== 2'd2) $display("FAIL arm_trig_after got %0d want 2", bus.ow_state); else n_pass++;
  endtask

  task automatic test_async_reset();
    arm(3'd5);
    sample(0, 1'b1, 1'b1);
    sample(1, 1'b1, 1'b0);
    n_checks++; if (bus.ow_state !== 2'd2) $display("FAIL areset_pre got %0d want 2", bus.ow_state); else n_pass++;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (bus.ow_state !== 2'd0 || bus.ow_rd_valid !== 1'b0 || bus.ow_wrapped !== 1'b0 || bus.ow_rd_last !== 1'b0)
      $display("FAIL areset_now got s=%0d v=%b w=%b l=%b want 0 0 0 0", bus.ow_state, bus.ow_rd_valid, bus.ow_wrapped, bus.ow_rd_last); else n_pass++;
    #1;
    rst_n = 1'b1;
    sample(2, 1'b1, 1'b1);
    n_checks++; if (bus.ow_state !== 2'd0) $display("FAIL areset_idle got %0d want 0", bus.ow_state); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_max_post();
    test_gaps();
    test_arm_priority();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
